fact_seq: RTL and testbench

- Sequential, parametrised factorial engine. Computes n! by iterative multiply, one multiply per clock, under a start/done handshake.
- Adds overflow detection and a busy indication.
- Sits beside the combinational factorial unit in the DSD lab datapath. Used where n exceeds 3 bits and a single-cycle multiplier chain is too large.

---
 rtl/fact_pkg.sv | 13 +
 rtl/fact_mul_step.sv | 23 ++
 rtl/fact_seq.sv | 117 +++++++++++
 tb/tb_fact_seq.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/fact_pkg.sv
// Shared types and default widths for the sequential factorial engine.
package fact_pkg;

   localparam int unsigned FACT_N_W = 4;
   localparam int unsigned FACT_Y_W = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } fact_state_t;

endpackage

// File: rtl/fact_mul_step.sv
// One factorial step: acc * i, truncated to Y_W bits, with a flag for lost high bits.
// Kept separate so the multiplier can be swapped for a DSP-mapped implementation.
module fact_mul_step
   import fact_pkg::*;
#(
   parameter int unsigned N_W = FACT_N_W,
   parameter int unsigned Y_W = FACT_Y_W
) (
   input  logic [Y_W-1:0] acc_i,
   input  logic [N_W-1:0] mul_i,
   output logic [Y_W-1:0] prod_o,
   output logic           ovf_o
);

   logic [Y_W+N_W-1:0] full;

   always_comb begin
      full   = {{N_W{1'b0}}, acc_i} * {{Y_W{1'b0}}, mul_i};
      prod_o = full[Y_W-1:0];
      ovf_o  = |full[Y_W+N_W-1:Y_W];
   end

endmodule

// File: rtl/fact_seq.sv
// Sequential factorial engine: one multiply per clock under a start/done handshake.
// Define FACT_SAT_EN to saturate y to all-ones when the result overflows.
module fact_seq
   import fact_pkg::*;
#(
   parameter int unsigned N_W = FACT_N_W,
   parameter int unsigned Y_W = FACT_Y_W
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [N_W-1:0] n,
   output logic           busy,
   output logic           done,
   output logic [Y_W-1:0] y,
   output logic           ovf
);

   // One extra bit so the counter never wraps when n is at its maximum.
   localparam int unsigned I_W = N_W + 1;

   fact_state_t    state_q, state_d;
   logic [N_W-1:0] n_reg_q, n_reg_d;
   logic [Y_W-1:0] acc_q, acc_d;
   logic [Y_W-1:0] y_q, y_d;
   logic [I_W-1:0] i_q, i_d;
   logic           ovf_int_q, ovf_int_d;
   logic           ovf_q, ovf_d;
   logic [Y_W-1:0] prod;
   logic           step_ovf;

   fact_mul_step #(
      .N_W(N_W),
      .Y_W(Y_W)
   ) u_mul_step (
      .acc_i (acc_q),
      .mul_i (i_q[N_W-1:0]),
      .prod_o(prod),
      .ovf_o (step_ovf)
   );

   always_comb begin
      state_d   = state_q;
      n_reg_d   = n_reg_q;
      acc_d     = acc_q;
      i_d       = i_q;
      ovf_int_d = ovf_int_q;
      y_d       = y_q;
      ovf_d     = ovf_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               n_reg_d   = n;
               acc_d     = Y_W'(1);
               i_d       = I_W'(1);
               ovf_int_d = 1'b0;
               if (n == '0) begin
                  state_d = DONE;
                  y_d     = Y_W'(1);
                  ovf_d   = 1'b0;
               end else begin
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            acc_d     = prod;
            ovf_int_d = ovf_int_q | step_ovf;
            i_d       = i_q + I_W'(1);
            if (i_q == {1'b0, n_reg_q}) begin
               // y/ovf are loaded on DONE entry and held until the next DONE.
               state_d = DONE;
               ovf_d   = ovf_int_d;
`ifdef FACT_SAT_EN
               y_d     = ovf_int_d ? {Y_W{1'b1}} : prod;
`else
               y_d     = prod;
`endif
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         n_reg_q   <= '0;
         acc_q     <= Y_W'(1);
         i_q       <= I_W'(1);
         ovf_int_q <= 1'b0;
         y_q       <= '0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         n_reg_q   <= n_reg_d;
         acc_q     <= acc_d;
         i_q       <= i_d;
         ovf_int_q <= ovf_int_d;
         y_q       <= y_d;
         ovf_q     <= ovf_d;
      end
   end

   always_comb begin
      busy = (state_q != IDLE);
      done = (state_q == DONE);
      y    = y_q;
      ovf  = ovf_q;
   end

endmodule

// File: tb/tb_fact_seq.sv
// Scoreboard bench for fact_seq: default build plus two 16-bit result configurations.
module tb_fact_seq;

   typedef struct {
      logic [31:0] y;
      logic        ovf;
      int unsigned cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  start = '0;
   logic [3:0]  n = '0;

   logic        busy0, done0, ovf0;
   logic [31:0] y0;
   logic        busy1, done1, ovf1;
   logic [15:0] y1;
   logic        busy2, done2, ovf2;
   logic [15:0] y2;

   int unsigned cyc = 0;
   int          vectors = 0;
   int          miscompares = 0;
   int unsigned yw_tab[3] = '{32, 16, 16};
   exp_t        q[3][$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   fact_seq u_dut0 (
      .clk(clk), .rst(rst), .start(start[0]), .n(n),
      .busy(busy0), .done(done0), .y(y0), .ovf(ovf0)
   );

   fact_seq #(.N_W(3), .Y_W(16)) u_dut1 (
      .clk(clk), .rst(rst), .start(start[1]), .n(n[2:0]),
      .busy(busy1), .done(done1), .y(y1), .ovf(ovf1)
   );

   fact_seq #(.N_W(4), .Y_W(16)) u_dut2 (
      .clk(clk), .rst(rst), .start(start[2]), .n(n),
      .busy(busy2), .done(done2), .y(y2), .ovf(ovf2)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      vectors++;
      if (obs !== exp_v) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp_v);
      end
   endtask

   // Reference: exact factorial in 64 bits, then reduce to the result width.
   function automatic exp_t model(input int unsigned nv, input int unsigned yw);
      logic [63:0] f;
      logic [63:0] mask;
      exp_t        e;
      f = 64'd1;
      for (int k = 2; k <= int'(nv); k++) f = f * 64'(k);
      mask  = (64'd1 << yw) - 64'd1;
      e.ovf = (f > mask);
      e.y   = 32'(f & mask);
`ifdef FACT_SAT_EN
      if (e.ovf) e.y = 32'(mask);
`endif
      e.cyc = 0;
      return e;
   endfunction

   task automatic score(input int id, input logic d, input logic [31:0] yv, input logic ov);
      exp_t e;
      if (q[id].size() == 0) begin
         check($sformatf("spurious_done%0d", id), 64'(d), 64'd0);
         return;
      end
      e = q[id].pop_front();
      check($sformatf("y%0d", id), 64'(yv), 64'(e.y));
      check($sformatf("ovf%0d", id), 64'(ov), 64'(e.ovf));
      check($sformatf("done_cycle%0d", id), 64'(cyc), 64'(e.cyc));
   endtask

   always @(negedge clk) if (done0) score(0, done0, y0, ovf0);
   always @(negedge clk) if (done1) score(1, done1, {16'd0, y1}, ovf1);
   always @(negedge clk) if (done2) score(2, done2, {16'd0, y2}, ovf2);

   // Called at a negedge with the DUT idle; returns at the negedge after the accept edge.
   task automatic start_op(input int id, input int unsigned nv);
      exp_t e;
      e     = model(nv, yw_tab[id]);
      e.cyc = cyc + 1 + nv;
      q[id].push_back(e);
      n         = 4'(nv);
      start[id] = 1'b1;
      @(negedge clk);
      start[id] = 1'b0;
   endtask

   // Waits for all expected results, then one more cycle so the DUT is back in IDLE.
   task automatic wait_idle(input int id);
      int k;
      k = 0;
      while (q[id].size() != 0 && k < 200) begin
         @(negedge clk);
         #1;
         k++;
      end
      check($sformatf("timeout%0d", id), 64'(q[id].size()), 64'd0);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned a;
      exp_t        e;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_busy", 64'(busy0), 64'd0);
      check("rst_done", 64'(done0), 64'd0);
      check("rst_y", 64'(y0), 64'd0);
      check("rst_ovf", 64'(ovf0), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      start_op(0, 5);
      check("busy_calc", 64'(busy0), 64'd1);
      check("done_calc", 64'(done0), 64'd0);
      wait_idle(0);
      check("busy_after", 64'(busy0), 64'd0);
      check("done_after", 64'(done0), 64'd0);

      start_op(0, 0);
      wait_idle(0);
      start_op(0, 1);
      wait_idle(0);

      start_op(0, 12);
      wait_idle(0);
      start_op(0, 13);
      wait_idle(0);
      start_op(0, 15);
      wait_idle(0);

      start_op(1, 7);
      wait_idle(1);
      start_op(2, 8);
      wait_idle(2);
      start_op(2, 9);
      wait_idle(2);

      // Held start: one IDLE cycle between results, n glitch mid-CALC ignored.
      a = cyc + 1;
      e = model(3, 32);
      for (int r = 0; r < 3; r++) begin
         e.cyc = a + 3 + 5 * r;
         q[0].push_back(e);
      end
      n        = 4'd3;
      start[0] = 1'b1;
      repeat (2) @(negedge clk);
      n = 4'd4;
      @(negedge clk);
      n = 4'd3;
      repeat (11) @(negedge clk);
      start[0] = 1'b0;
      wait_idle(0);

      // Reset mid-CALC aborts the computation without a done pulse.
      start_op(0, 10);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      q[0].delete();
      @(negedge clk);
      rst = 1'b0;
      check("abort_y", 64'(y0), 64'd0);
      check("abort_ovf", 64'(ovf0), 64'd0);
      check("abort_busy", 64'(busy0), 64'd0);
      check("abort_done", 64'(done0), 64'd0);
      repeat (15) @(negedge clk);
      start_op(0, 4);
      wait_idle(0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
